// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with majority vote, parity and stop checks
module uart_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      DATA_VALID,
    output logic                      PAR_ERR,
    output logic                      STP_ERR,
    output logic                      busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] ONE_P = 1;

    logic [2:0]                state;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BW-1:0]             bit_cnt;
    logic [PRESCALE_WIDTH-1:0] presc_q;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic [1:0]                samp;
    logic                      bit_val;
    logic                      par_mis;
    logic [DATA_WIDTH-1:0]     shreg;

    logic [PRESCALE_WIDTH-1:0] half;
    logic                      last_edge;
    logic                      at_s0;
    logic                      at_s1;
    logic                      at_s2;
    logic                      vote;

    assign half      = presc_q >> 1;
    assign last_edge = (edge_cnt == presc_q - ONE_P);
    assign at_s0     = (edge_cnt == half - ONE_P);
    assign at_s1     = (edge_cnt == half);
    assign at_s2     = (edge_cnt == half + ONE_P);
    // The third sample is taken live so the voted bit is registered on the same edge
    assign vote      = (samp[0] & samp[1]) | (samp[0] & RX_IN) | (samp[1] & RX_IN);
    assign busy      = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            samp       <= '0;
            bit_val    <= 1'b0;
            par_mis    <= 1'b0;
            shreg      <= '0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (state != IDLE) begin
                edge_cnt <= last_edge ? '0 : edge_cnt + ONE_P;
                if (at_s0) samp[0] <= RX_IN;
                if (at_s1) samp[1] <= RX_IN;
                if (at_s2) bit_val <= vote;
            end

            case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        state     <= START;
                        edge_cnt  <= '0;
                        presc_q   <= PRESCALE;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_mis   <= 1'b0;
                    end
                end
                START: begin
                    if (at_s2 && vote) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end else if (last_edge) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (last_edge) begin
                        shreg[bit_cnt] <= bit_val;
                        if (bit_cnt == LAST_BIT)
                            state <= par_en_q ? PARITY : STOP;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (last_edge) begin
                        par_mis <= (bit_val != ((^shreg) ^ par_typ_q));
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (last_edge) begin
                        if (bit_val && !par_mis) begin
                            P_DATA     <= shreg;
                            DATA_VALID <= 1'b1;
                        end
                        STP_ERR <= !bit_val;
                        PAR_ERR <= par_mis;
                        par_mis <= 1'b0;
                        // A low line here is already the next frame's start bit
                        if (!RX_IN) begin
                            state     <= START;
                            presc_q   <= PRESCALE;
                            par_en_q  <= PAR_EN;
                            par_typ_q <= PAR_TYP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] PRESCALE = 6'd8;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;
    logic       busy;

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .PRESCALE(PRESCALE), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] cyc;
        logic        dv;
        logic        pe;
        logic        se;
        logic [7:0]  pd;
    } ev_t;

    int         cyc = 0;
    int         busy_cnt = 0;
    int         errors = 0;
    int         checks = 0;
    int         cur_p = 8;
    logic [7:0] model_pdata = 8'h00;
    ev_t        got_q[$];
    ev_t        exp_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (DATA_VALID || PAR_ERR || STP_ERR)
            got_q.push_back({32'(cyc), DATA_VALID, PAR_ERR, STP_ERR, P_DATA});
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic drive_bit(input logic b);
        RX_IN = b;
        repeat (cur_p) @(negedge CLK);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Drives one frame and queues the outcome the receiver should report for it
    task automatic send_frame(input logic [7:0] d, input int p, input logic pe, input logic pt,
                              input logic par_flip, input logic stop_bit, input logic scramble);
        int   start;
        logic par_bit;
        logic perr;
        logic serr;
        ev_t  e;
        cur_p    = p;
        PRESCALE = 6'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        par_bit  = (($countones(d) % 2) == 1) ^ pt ^ par_flip;
        start    = cyc;
        drive_bit(1'b0);
        if (scramble) begin
            PRESCALE = (p == 8) ? 6'd16 : 6'd8;
            PAR_EN   = !pe;
            PAR_TYP  = !pt;
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pe) drive_bit(par_bit);
        drive_bit(stop_bit);
        perr  = pe && par_flip;
        serr  = !stop_bit;
        e.cyc = 32'(start + 1 + (pe ? 11 : 10) * p);
        e.dv  = !perr && !serr;
        e.pe  = perr;
        e.se  = serr;
        if (e.dv) model_pdata = d;
        e.pd  = model_pdata;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({P_DATA, DATA_VALID, PAR_ERR, STP_ERR} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got P_DATA=%h dv=%b pe=%b se=%b, expected all 0", P_DATA, DATA_VALID, PAR_ERR, STP_ERR);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_basic();
        got_q.delete(); exp_q.delete(); busy_cnt = 0;
        send_frame(8'h81, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(30);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d events, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_ev%0d: got cyc=%0d dv=%b pe=%b se=%b pd=%h, expected cyc=%0d dv=%b pe=%b se=%b pd=%h", i,
                         got_q[i].cyc, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].pd,
                         exp_q[i].cyc, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].pd);
            end
        end
        checks++;
        if (busy_cnt !== 88) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, expected 88", busy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        got_q.delete(); exp_q.delete(); busy_cnt = 0;
        send_frame(8'h0A, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(8'h91, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(40);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d events, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_ev%0d: got cyc=%0d dv=%b pe=%b se=%b pd=%h, expected cyc=%0d dv=%b pe=%b se=%b pd=%h", i,
                         got_q[i].cyc, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].pd,
                         exp_q[i].cyc, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].pd);
            end
        end
        checks++;
        if (busy_cnt !== 352) begin
            errors++;
            $display("FAIL b2b_busy_cycles: got %0d, expected 352", busy_cnt);
        end
    endtask

    task automatic test_parity_error();
        got_q.delete(); exp_q.delete();
        send_frame(8'h5A, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(10);
        send_frame(8'h91, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(30);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL parerr_count: got %0d events, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL parerr_ev%0d: got cyc=%0d dv=%b pe=%b se=%b pd=%h, expected cyc=%0d dv=%b pe=%b se=%b pd=%h", i,
                         got_q[i].cyc, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].pd,
                         exp_q[i].cyc, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].pd);
            end
        end
        checks++;
        if (P_DATA !== model_pdata) begin
            errors++;
            $display("FAIL parerr_hold: got P_DATA=%h, expected %h", P_DATA, model_pdata);
        end
    endtask

    task automatic test_stop_error();
        got_q.delete(); exp_q.delete();
        send_frame(8'h55, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(60);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL stperr_count: got %0d events, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stperr_ev%0d: got cyc=%0d dv=%b pe=%b se=%b pd=%h, expected cyc=%0d dv=%b pe=%b se=%b pd=%h", i,
                         got_q[i].cyc, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].pd,
                         exp_q[i].cyc, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].pd);
            end
        end
    endtask

    task automatic test_glitch();
        got_q.delete(); exp_q.delete();
        cur_p = 8; PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_c5: got %b, expected 1", busy);
        end
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle_c6: got %b, expected 0", busy);
        end
        idle(12);
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(30);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL glitch_count: got %0d events, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL glitch_ev%0d: got cyc=%0d dv=%b pe=%b se=%b pd=%h, expected cyc=%0d dv=%b pe=%b se=%b pd=%h", i,
                         got_q[i].cyc, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].pd,
                         exp_q[i].cyc, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].pd);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        got_q.delete(); exp_q.delete();
        cur_p = 16; PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        RX_IN = 1'b1;
        repeat (8) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if ({P_DATA, DATA_VALID, PAR_ERR, STP_ERR, busy} !== 12'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got P_DATA=%h dv=%b pe=%b se=%b busy=%b, expected all 0",
                     P_DATA, DATA_VALID, PAR_ERR, STP_ERR, busy);
        end
        model_pdata = 8'h00;
        idle(40);
        send_frame(8'hF0, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(40);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL midreset_count: got %0d events, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midreset_ev%0d: got cyc=%0d dv=%b pe=%b se=%b pd=%h, expected cyc=%0d dv=%b pe=%b se=%b pd=%h", i,
                         got_q[i].cyc, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].pd,
                         exp_q[i].cyc, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].pd);
            end
        end
    endtask

    task automatic test_random();
        int p;
        int gap;
        got_q.delete(); exp_q.delete();
        for (int n = 0; n < 14; n++) begin
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            send_frame(8'($urandom), p, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), 1'($urandom));
            gap = $urandom_range(0, 2);
            if (gap != 0) idle(gap * 7);
        end
        idle(400);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d events, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_ev%0d: got cyc=%0d dv=%b pe=%b se=%b pd=%h, expected cyc=%0d dv=%b pe=%b se=%b pd=%h", i,
                         got_q[i].cyc, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].pd,
                         exp_q[i].cyc, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].pd);
            end
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        idle(5);
        test_basic();
        test_back_to_back();
        test_parity_error();
        test_stop_error();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver paired with the UART transmitter. It consumes the serial line that the transmitter drives.
- Oversamples RX_IN at PRESCALE clocks per bit and takes a 3-sample majority vote at mid-bit.
- Checks the start glitch, parity and stop bit, then delivers the recovered byte on P_DATA with a one-cycle DATA_VALID pulse.
- Sits downstream of the line. It feeds the data-sync/register-file path of the system.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (LSB first).
- PRESCALE_WIDTH, 6, width of the PRESCALE input.

Ports:
- CLK  input  1  receiver clock (oversampling clock).
- RST  input  1  reset. Synchronous, active-high.
- RX_IN  input  1  serial line, idle high. Already synchronised to CLK by a separate stage.
- PAR_EN  input  1  1 = a parity bit follows the data bits.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- PRESCALE  input  PRESCALE_WIDTH  oversample ratio. Legal values: 8, 16, 32.
- P_DATA  output  DATA_WIDTH  last good received byte.
- DATA_VALID  output  1  one-cycle pulse when P_DATA is updated.
- PAR_ERR  output  1  one-cycle pulse: parity mismatch, frame discarded.
- STP_ERR  output  1  one-cycle pulse: stop bit sampled 0, frame discarded.
- busy  output  1  high while a frame is being received (any state other than IDLE).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, busy=0, FSM=IDLE, all counters 0. Reset mid-frame aborts the frame with no pulses.
- Config latch: PAR_EN, PAR_TYP and PRESCALE are latched when a start is detected. Changes mid-frame are ignored.
- Counters:
  - edge_cnt runs 0..PRESCALE-1 within each bit, then wraps.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling: RX_IN is sampled at edge_cnt = P/2-1, P/2 and P/2+1 (P = latched PRESCALE). The bit value is the majority (2 of 3) and is valid from edge_cnt = P/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: RX_IN=0 -> START, edge_cnt=0 in that cycle.
  - START: if the sampled bit is 1 (glitch), return to IDLE at edge_cnt=P/2+2 with no outputs. Otherwise go to DATA when edge_cnt=P-1.
  - DATA: shift the sampled bit into the shift register at bit position bit_cnt. At edge_cnt=P-1 of the last bit, go to PARITY if PAR_EN, else STOP.
  - PARITY: the expected bit is the XOR of the data bits, inverted when PAR_TYP=1. Record a mismatch flag. At edge_cnt=P-1 go to STOP.
  - STOP: evaluate at edge_cnt=P-1.
    - Stop bit sampled 1 and no parity mismatch: P_DATA <= shift register, DATA_VALID=1 for one cycle.
    - Stop bit sampled 0: STP_ERR=1.
    - Parity mismatch: PAR_ERR=1.
    - Both conditions: both error pulses assert. DATA_VALID is never asserted with any error.
    - Next state: START directly if RX_IN=0 in that cycle (back-to-back frames), else IDLE.
- Latency: the outputs register in the cycle after STOP's last edge. DATA_VALID rises (11*P) cycles after the first low sample with parity, or (10*P) without, counting that first low sample as cycle 0.
- P_DATA holds its value until the next good frame. Error frames leave it unchanged.
- busy = (state != IDLE). It drops together with the DATA_VALID/error pulse unless the receiver goes back-to-back into START.
- Illegal PRESCALE values: behaviour undefined. The bench uses only 8, 16 and 32.

Test Plan:
- Reset, P=8, PAR_EN=1, PAR_TYP=0. Send 0x81 with parity bit 0 -> DATA_VALID pulse at cycle 88, P_DATA=0x81, no errors, busy high for cycles 0..87.
- P=16, PAR_EN=1, PAR_TYP=1. Send 0x0A (parity 1) and then immediately 0x91 (odd parity bit 0), no idle gap -> two DATA_VALID pulses 176 cycles apart, P_DATA=0x0A then 0x91, busy never drops between the frames.
- P=8, PAR_EN=1, PAR_TYP=0. Send 0x91 with wrong parity bit 0 -> PAR_ERR pulse, no DATA_VALID, P_DATA retains its previous value.
- P=32, PAR_EN=0. Send 0x55 with stop bit forced 0 -> STP_ERR pulse at cycle 320, no DATA_VALID.
- P=8, drive a 2-cycle low glitch on idle RX_IN -> FSM returns to IDLE by cycle 6, no pulses. A following valid 0x3C frame is received correctly.
- Assert RST during DATA bit 4 of a 0xF0 frame -> all outputs 0 in the next cycle, no pulses. A subsequent 0xF0 frame is received cleanly.
